// File: rtl/fifo_pkg.sv
// Shared definitions for the sync_fifo family: pointer sizing, parameter legality
// helpers and the sticky error-flag bundle.
package fifo_pkg;

   typedef struct packed {
      logic overflow;
      logic underflow;
   } err_flags_t;

   // Pointer index width; a 1-entry FIFO still needs one index bit.
   function automatic int ptr_width(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

   function automatic bit is_pow2(input int value);
      return (value >= 2) && ((value & (value - 1)) == 0);
   endfunction

   function automatic bit almost_full_thr_ok(input int thr, input int depth);
      return (thr >= 1) && (thr <= depth);
   endfunction

   function automatic bit almost_empty_thr_ok(input int thr, input int depth);
      return (thr >= 0) && (thr <= depth - 1);
   endfunction

endpackage

// File: rtl/fifo_ptr.sv
// Wrap-bit FIFO pointer: PtrWidth index bits plus one lap bit that toggles on
// every wrap, so equal indices can be told apart as full or empty.
module fifo_ptr #(
   parameter int PtrWidth = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              inc,
   output logic [PtrWidth:0] ptr
);

   localparam logic [PtrWidth:0] One = (PtrWidth + 1)'(1);

   // NOTE: state registers use non-blocking assignments so every flop samples
   // pre-edge values regardless of process evaluation order.
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr <= '0;
      end else if (inc) begin
         ptr <= ptr + One;
      end
   end

endmodule

// File: rtl/sync_fifo_ft.sv
// Single-clock FIFO with occupancy count, programmable almost flags, selectable
// show-ahead/registered read port and sticky overflow/underflow flags.
module sync_fifo_ft
   import fifo_pkg::*;
#(
   parameter int DataWidth       = 32,
   parameter int Depth           = 8,
   parameter int AlmostFullThr   = Depth - 2,
   parameter int AlmostEmptyThr  = 2,
   parameter int ShowAhead       = 1,
   parameter int PtrWidth        = ptr_width(Depth)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 writeEn,
   input  logic [DataWidth-1:0] writeData,
   input  logic                 readEn,
   output logic [DataWidth-1:0] readData,
   output logic                 full,
   output logic                 empty,
   output logic                 almostFull,
   output logic                 almostEmpty,
   output logic [PtrWidth:0]    count,
   input  logic                 clearErr,
   output logic                 overflow,
   output logic                 underflow
);

   if (!is_pow2(Depth)) begin : g_bad_depth
      $error("sync_fifo_ft: Depth must be a power of two >= 2");
   end
   if (PtrWidth != ptr_width(Depth)) begin : g_bad_ptr_width
      $error("sync_fifo_ft: PtrWidth is derived from Depth and must not be overridden");
   end
   if (!almost_full_thr_ok(AlmostFullThr, Depth)) begin : g_bad_af_thr
      $error("sync_fifo_ft: AlmostFullThr out of range 1..Depth");
   end
   if (!almost_empty_thr_ok(AlmostEmptyThr, Depth)) begin : g_bad_ae_thr
      $error("sync_fifo_ft: AlmostEmptyThr out of range 0..Depth-1");
   end

   localparam logic [PtrWidth:0] DepthCnt = (PtrWidth + 1)'(Depth);
   localparam logic [PtrWidth:0] AfThr    = (PtrWidth + 1)'(AlmostFullThr);
   localparam logic [PtrWidth:0] AeThr    = (PtrWidth + 1)'(AlmostEmptyThr);

   logic [PtrWidth:0]    wr_ptr;
   logic [PtrWidth:0]    rd_ptr;
   logic                 wr_acc;
   logic                 rd_acc;
   logic [DataWidth-1:0] mem [Depth];
   logic [DataWidth-1:0] head_word;
   err_flags_t           err;

   // Occupancy is the modular pointer difference; the lap bit resolves full vs empty.
   assign count       = wr_ptr - rd_ptr;
   assign full        = (count == DepthCnt);
   assign empty       = (count == '0);
   assign almostFull  = (count >= AfThr);
   assign almostEmpty = (count <= AeThr);

   assign wr_acc = writeEn && !full && !rst;
   assign rd_acc = readEn && !empty && !rst;

   fifo_ptr #(.PtrWidth(PtrWidth)) u_wr_ptr (
      .clk (clk),
      .rst (rst),
      .inc (wr_acc),
      .ptr (wr_ptr)
   );

   fifo_ptr #(.PtrWidth(PtrWidth)) u_rd_ptr (
      .clk (clk),
      .rst (rst),
      .inc (rd_acc),
      .ptr (rd_ptr)
   );

   // NOTE: the storage array has no reset; its contents are only observable
   // behind a valid pointer, so resetting it would only cost a clear network.
   always_ff @(posedge clk) begin
      if (wr_acc) begin
         mem[wr_ptr[PtrWidth-1:0]] <= writeData;
      end
   end

   assign head_word = mem[rd_ptr[PtrWidth-1:0]];

   if (ShowAhead != 0) begin : g_show_ahead
      assign readData = head_word;
   end else begin : g_registered
      logic [DataWidth-1:0] rd_q;

      always_ff @(posedge clk) begin
         if (rst) begin
            rd_q <= '0;
         end else if (rd_acc) begin
            rd_q <= head_word;
         end
      end

      assign readData = rd_q;
   end

   // A fresh error outranks clearErr in the same cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         err <= '0;
      end else begin
         err.overflow  <= (writeEn && full)  || (err.overflow  && !clearErr);
         err.underflow <= (readEn  && empty) || (err.underflow && !clearErr);
      end
   end

   assign overflow  = err.overflow;
   assign underflow = err.underflow;

   always_ff @(posedge clk) begin
      if (!rst) begin
         assert (count <= DepthCnt)
            else $error("sync_fifo_ft: occupancy exceeds Depth");
      end
   end

endmodule

// File: doc/sync_fifo_ft.md
# sync_fifo_ft

Parametrised single-clock FIFO, next generation of the team's basic FIFO: adds programmable almost-full/almost-empty thresholds, an occupancy count, selectable show-ahead or registered read mode, and sticky overflow/underflow error flags. Sits between producer and consumer datapaths in the same clock domain. Underlying storage and pointer discipline (extra wrap bit on each pointer) are unchanged, so existing formal properties carry over.

## Interface
- DataWidth, 32, data word width
- Depth, 8, number of entries; power of two, >= 2
- AlmostFullThr, Depth-2, almostFull asserted when count >= this; range 1..Depth
- AlmostEmptyThr, 2, almostEmpty asserted when count <= this; range 0..Depth-1
- ShowAhead, 1, 1 = readData combinational from head entry; 0 = readData registered, updated one cycle after accepted read
- PtrWidth, $clog2(Depth), derived; not to be overridden

- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-high
- writeEn  in  1  write request
- writeData  in  DataWidth  write data
- readEn  in  1  read request
- readData  out  DataWidth  read data
- full  out  1  count == Depth
- empty  out  1  count == 0
- almostFull  out  1  count >= AlmostFullThr
- almostEmpty  out  1  count <= AlmostEmptyThr
- count  out  PtrWidth+1  current occupancy, 0..Depth
- clearErr  in  1  clears sticky error flags
- overflow  out  1  sticky: write requested while full
- underflow  out  1  sticky: read requested while empty

## Operation
- Write accepted iff writeEn && !full; stores writeData at mem[wrPtr[PtrWidth-1:0]], wrPtr increments.
- Read accepted iff readEn && !empty; rdPtr increments.
- Pointers are PtrWidth+1 bits; low bits wrap Depth-1 -> 0, MSB toggles on wrap.
- count = wrPtr - rdPtr modulo 2^(PtrWidth+1); full/empty/almost flags derived from count combinationally off registered pointers.
- Simultaneous read and write, neither full nor empty: both accepted, count unchanged.
- Full with writeEn && readEn: read accepted, write rejected, overflow set. Empty with both: write accepted, read rejected, underflow set. No write-through.
- Rejected accesses never move pointers or modify memory.
- ShowAhead=1: readData = mem[rdPtr] whenever !empty; undefined (don't-care) when empty.
- ShowAhead=0: readData <= mem[rdPtr] on accepted read; holds value otherwise.
- overflow set on writeEn && full; underflow set on readEn && empty; clearErr clears both; set wins over clear in the same cycle.
- Memory array is not reset.

## Timing
- Reset (sync, rst sampled high): wrPtr=rdPtr=0, count=0, empty=1, full=0, almostEmpty=1, almostFull=0, overflow=underflow=0, registered readData=0. Takes effect at the edge where rst is high; accesses in that cycle ignored.
- Reset mid-operation discards all contents; no partial drain.
- Write latency: accepted write visible in count/flags the next cycle; ShowAhead=1 readData shows the word the cycle after it is written into an empty FIFO.
- ShowAhead=0 read latency: 1 cycle from accepted readEn to readData.
- Error flags update one cycle after the offending request.

## Structure
- Shared package fifo_pkg: pointer width function, parameter legality checks (power-of-two Depth, threshold ranges) as elaboration-time asserts, common error-flag typedef.
- One sub-module fifo_ptr: wrap-bit pointer register with increment enable and sync reset, instantiated for write and read sides.

## Test plan
- Reset then write 8 words 0x0..0x7 (Depth 8): count 1..8, almostFull at count 6, full at 8, empty deasserts after first write.
- Fill, then writeEn with 0xDEAD while full: pointers/memory unchanged, overflow=1 next cycle, stays until clearErr pulse.
- Drain 8 words in ShowAhead=0: readData 0x0..0x7 each one cycle after readEn; empty after last; extra readEn sets underflow.
- Count 4, writeEn && readEn for 20 cycles: count stays 4, data order preserved across pointer wrap (MSB toggles).
- Full plus simultaneous readEn/writeEn: read accepted, count 7, overflow=1; clearErr same cycle as new overflow keeps overflow=1.
- rst pulse with count 5: next cycle count=0, empty=1, almostEmpty=1, error flags 0, registered readData 0.
